// File: rtl/sequence_detect_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sequence_detect_pkg
// Brief    : Shared state encoding and pattern constants for sequence_detect.
// Revision : 1.0 - initial release
// ============================================================================
package sequence_detect_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_1    = 2'b01,
        S_10   = 2'b10,
        S_101  = 2'b11
    } state_t;

    localparam logic [3:0] PATTERN     = 4'b1011;
    localparam int         PATTERN_LEN = 4;

    // Each state's encoding equals the length of the matched prefix, so the
    // bit it waits for next is the following pattern bit, MSB first.
    function automatic logic expected_bit(input state_t s);
        logic [1:0] idx;
        idx = 2'(PATTERN_LEN - 1) - s;
        return PATTERN[idx];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sequence_detect.sv
`default_nettype none
// ============================================================================
// Module   : sequence_detect
// Brief    : Overlapping Mealy detector for serial pattern 1011. Optional
//            saturating detection counter enabled by SEQ_DETECT_COUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sequence_detect
    import sequence_detect_pkg::*;
`ifdef SEQ_DETECT_COUNT_EN
#(
    parameter int CNT_W = 16
)
`endif
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    output logic             out
`ifdef SEQ_DETECT_COUNT_EN
    ,
    output logic [CNT_W-1:0] det_count
`endif
);

    state_t current_state;
    state_t next_state;
    logic   w_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            current_state <= S_IDLE;
        end else begin
            current_state <= next_state;
        end
    end

    // On a miss each state falls back to the longest prefix still matched.
    always_comb begin
        w_hit      = (in == expected_bit(current_state));
        next_state = S_IDLE;
        case (current_state)
            S_IDLE:  next_state = w_hit ? S_1   : S_IDLE;
            S_1:     next_state = w_hit ? S_10  : S_1;
            S_10:    next_state = w_hit ? S_101 : S_IDLE;
            S_101:   next_state = w_hit ? S_1   : S_10;
            default: next_state = S_IDLE;
        endcase
        out = (current_state == S_101) && w_hit && !rst;
    end

`ifdef SEQ_DETECT_COUNT_EN
    logic [CNT_W-1:0] r_det_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_det_count <= '0;
        end else if (out && (r_det_count != {CNT_W{1'b1}})) begin
            r_det_count <= r_det_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign det_count = r_det_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sequence_detect.sv
`default_nettype none
// ============================================================================
// Module   : tb_sequence_detect
// Brief    : Self-checking bench for sequence_detect (scoreboard of expected
//            out bits from a shift-register reference model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sequence_detect;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in  = 1'b0;
    logic out;
`ifdef SEQ_DETECT_COUNT_EN
    logic [3:0] det_count;
`endif

    int   n_checks  = 0;
    int   n_fail    = 0;
    logic exp_q[$];
    logic [2:0] hist      = 3'b000;
    int         nbits     = 0;
    int         cnt_model = 0;

`ifdef SEQ_DETECT_COUNT_EN
    sequence_detect #(.CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in),
        .out       (out),
        .det_count (det_count)
    );
`else
    sequence_detect dut (
        .clk (clk),
        .rst (rst),
        .in  (in),
        .out (out)
    );
`endif

    always #5 clk = ~clk;

    task automatic model_reset();
        hist      = 3'b000;
        nbits     = 0;
        cnt_model = 0;
    endtask

    // Drive one bit mid-cycle, queue the model's expected out for it.
    task automatic send_bit(input logic b);
        logic e;
        @(negedge clk);
        in = b;
        e  = (nbits >= 3) && ({hist, b} == 4'b1011);
        exp_q.push_back(e);
        if (e && cnt_model < 15) cnt_model++;
        hist = {hist[1:0], b};
        nbits++;
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            rst = 1'b1;
            in  = 1'b1;
            #1;
            n_checks++;
            if (out !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_out cycle %0d: out=%b expected 0", c, out);
            end
            @(posedge clk);
            #1;
            n_checks++;
            if (dut.current_state !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_state cycle %0d: state=%b expected 00", c, dut.current_state);
            end
`ifdef SEQ_DETECT_COUNT_EN
            n_checks++;
            if (det_count !== 4'h0) begin
                n_fail++;
                $display("FAIL reset_count: det_count=%h expected 0", det_count);
            end
`endif
        end
        @(negedge clk);
        rst = 1'b0;
        in  = 1'b0;
        model_reset();
    endtask

    task automatic test_single_match();
        logic [15:0] pat;
        logic        e;
        int          pulses;
        int          pos;
        pat    = 16'b0001011000000000;
        pulses = 0;
        pos    = -1;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            send_bit(pat[15-i]);
            e = exp_q.pop_front();
            n_checks++;
            if (out !== e) begin
                n_fail++;
                $display("FAIL single_match bit %0d: out=%b expected %b", i, out, e);
            end
            if (out === 1'b1) begin
                pulses++;
                pos = i;
            end
        end
        n_checks++;
        if (pulses != 1 || pos != 6) begin
            n_fail++;
            $display("FAIL single_match_pulses: count=%0d pos=%0d expected count=1 pos=6", pulses, pos);
        end
`ifdef SEQ_DETECT_COUNT_EN
        @(posedge clk);
        #1;
        n_checks++;
        if (det_count !== 4'd1) begin
            n_fail++;
            $display("FAIL single_match_count: det_count=%0d expected 1", det_count);
        end
`endif
    endtask

    task automatic test_overlap();
        logic [6:0] pat;
        logic [6:0] seen;
        logic       e;
        pat  = 7'b1011011;
        seen = 7'b0;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            send_bit(pat[6-i]);
            e = exp_q.pop_front();
            n_checks++;
            if (out !== e) begin
                n_fail++;
                $display("FAIL overlap bit %0d: out=%b expected %b", i, out, e);
            end
            seen[6-i] = (out === 1'b1);
        end
        // Pulses expected on bits 4 and 7 (1-based).
        n_checks++;
        if (seen !== 7'b0001001) begin
            n_fail++;
            $display("FAIL overlap_pulses: pulse map=%b expected 0001001", seen);
        end
`ifdef SEQ_DETECT_COUNT_EN
        @(posedge clk);
        #1;
        n_checks++;
        if (det_count !== 4'd2) begin
            n_fail++;
            $display("FAIL overlap_count: det_count=%0d expected 2", det_count);
        end
`endif
    endtask

    task automatic test_near_miss();
        logic [15:0] pat;
        logic        e;
        pat = 16'b1001_0100_1110_0000;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            send_bit(pat[15-i]);
            e = exp_q.pop_front();
            n_checks++;
            if (out !== e || out !== 1'b0) begin
                n_fail++;
                $display("FAIL near_miss bit %0d: out=%b expected 0 (model %b)", i, out, e);
            end
        end
    endtask

    task automatic test_reset_mid_pattern();
        logic [2:0] pre;
        logic [4:0] post;
        logic       e;
        int         pulses;
        pre    = 3'b101;
        post   = 5'b11011;
        pulses = 0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send_bit(pre[2-i]);
            e = exp_q.pop_front();
            n_checks++;
            if (out !== e) begin
                n_fail++;
                $display("FAIL mid_reset_prefix bit %0d: out=%b expected %b", i, out, e);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        in  = 1'b1;
        #1;
        n_checks++;
        if (out !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_gate: out=%b expected 0 while rst high", out);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            send_bit(post[4-i]);
            e = exp_q.pop_front();
            n_checks++;
            if (out !== e) begin
                n_fail++;
                $display("FAIL mid_reset_after bit %0d: out=%b expected %b", i, out, e);
            end
            if (out === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL mid_reset_pulses: count=%0d expected 1", pulses);
        end
    endtask

`ifdef SEQ_DETECT_COUNT_EN
    task automatic test_saturation();
        logic [3:0] pat;
        logic       e;
        pat = 4'b1011;
        do_reset();
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < 4; i++) begin
                send_bit(pat[3-i]);
                e = exp_q.pop_front();
                n_checks++;
                if (out !== e) begin
                    n_fail++;
                    $display("FAIL saturation rep %0d bit %0d: out=%b expected %b", r, i, out, e);
                end
            end
            @(posedge clk);
            #1;
            n_checks++;
            if (det_count !== ((r + 1 > 15) ? 4'hF : 4'(r + 1))) begin
                n_fail++;
                $display("FAIL saturation_count rep %0d: det_count=%0d expected %0d", r, det_count, (r + 1 > 15) ? 15 : r + 1);
            end
        end
    endtask
`endif

    task automatic test_random();
        logic e;
        int   bad;
        bad = 0;
        do_reset();
        for (int i = 0; i < 100; i++) begin
            send_bit(1'($urandom_range(0, 1)));
            e = exp_q.pop_front();
            n_checks++;
            if (out !== e) begin
                n_fail++;
                bad++;
                if (bad < 10) $display("FAIL random bit %0d: out=%b expected %b", i, out, e);
            end
        end
`ifdef SEQ_DETECT_COUNT_EN
        @(posedge clk);
        #1;
        n_checks++;
        if (det_count !== 4'(cnt_model)) begin
            n_fail++;
            $display("FAIL random_count: det_count=%0d expected %0d", det_count, cnt_model);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single_match();
        test_overlap();
        test_near_miss();
        test_reset_mid_pattern();
`ifdef SEQ_DETECT_COUNT_EN
        test_saturation();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
